bird_collision: RTL and testbench

BIRD_COLLISION -- requirements
Module: bird_collision

---
 rtl/bird_collision.sv | 142 ++++++++++++++
 tb/tb_bird_collision.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bird_collision.sv
// Flappy-bird style game controller: tracks IDLE/PLAY/DEAD, detects collisions
// between a fixed-column bird and the current pipe, and counts cleared pipes.
module bird_collision #(
    parameter int BIRD_X    = 100,
    parameter int BIRD_SIZE = 32,
    parameter int PIPE_W    = 52,
    parameter int GAP_H     = 120,
    parameter int SCREEN_H  = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] bird_y,
    input  logic [9:0] pipe_x,
    input  logic [9:0] gap_y,
    input  logic       frame_tick,
    input  logic       start_btn,
    output logic [1:0] game_state,
    output logic [7:0] score,
    output logic       hit,
    output logic       freeze
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    // Geometry is done in 12 bits so sums of 10-bit coordinates and sizes never wrap.
    localparam logic [11:0] BIRD_LEFT  = 12'(BIRD_X);
    localparam logic [11:0] BIRD_RIGHT = 12'(BIRD_X + BIRD_SIZE);
    localparam logic [11:0] GROUND_Y   = 12'(SCREEN_H - BIRD_SIZE);

    state_t      state_reg, state_next;
    logic [7:0]  score_reg, score_next;
    logic        passed_reg, passed_next;
    logic        hit_reg, hit_next;
    logic        btn_prev_reg;
    logic        btn_armed_reg;

    logic [11:0] bird_top, bird_bot;
    logic [11:0] pipe_left, pipe_right;
    logic [11:0] gap_top, gap_bot;
    logic        h_overlap, outside_gap, ground_hit, collision, pipe_behind;
    logic        start_edge;

    assign bird_top   = {2'b00, bird_y};
    assign bird_bot   = bird_top + 12'(BIRD_SIZE);
    assign pipe_left  = {2'b00, pipe_x};
    assign pipe_right = pipe_left + 12'(PIPE_W);
    assign gap_top    = {2'b00, gap_y};
    assign gap_bot    = gap_top + 12'(GAP_H);

    // Touching a pipe edge or a gap edge exactly is still safe, hence strict compares.
    assign h_overlap   = (pipe_left < BIRD_RIGHT) && (pipe_right > BIRD_LEFT);
    assign outside_gap = (bird_top < gap_top) || (bird_bot > gap_bot);
    assign ground_hit  = (bird_top >= GROUND_Y);
    assign collision   = (h_overlap && outside_gap) || ground_hit;
    assign pipe_behind = (pipe_right <= BIRD_LEFT);

    // The armed flag makes a button still held across reset release wait for a
    // release before its next press can count as an edge.
    assign start_edge = start_btn && !btn_prev_reg && btn_armed_reg;

    // Button history: previous level plus the "seen released since reset" flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_reg  <= 1'b0;
            btn_armed_reg <= 1'b0;
        end else begin
            btn_prev_reg <= start_btn;
            if (!start_btn) begin
                btn_armed_reg <= 1'b1;
            end
        end
    end

    // Game state, score, pass tracking and hit pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            score_reg  <= 8'd0;
            passed_reg <= 1'b0;
            hit_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            score_reg  <= score_next;
            passed_reg <= passed_next;
            hit_reg    <= hit_next;
        end
    end

    // Next-state logic: frame evaluation only happens in PLAY on frame_tick.
    always_comb begin
        state_next  = state_reg;
        score_next  = score_reg;
        passed_next = passed_reg;
        hit_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next  = ST_PLAY;
                    score_next  = 8'd0;
                    passed_next = 1'b0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (collision) begin
                        // A crash on the same frame as a pass does not score.
                        state_next = ST_DEAD;
                        hit_next   = 1'b1;
                    end else if (pipe_behind) begin
                        if (!passed_reg) begin
                            passed_next = 1'b1;
                            if (score_reg != 8'hFF) begin
                                score_next = score_reg + 8'd1;
                            end
                        end
                    end else begin
                        // Pipe is level with or ahead of the bird (e.g. freshly spawned).
                        passed_next = 1'b0;
                    end
                end
            end
            ST_DEAD: begin
                if (start_edge) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign game_state = state_reg;
    assign score      = score_reg;
    assign hit        = hit_reg;
    assign freeze     = (state_reg != ST_PLAY);

endmodule

// File: tb/tb_bird_collision.sv
// Directed testbench for bird_collision: game flow, geometry edges, scoring,
// saturation and asynchronous reset behaviour.
module tb_bird_collision;

    logic       clk;
    logic       reset_n;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [9:0] gap_y;
    logic       frame_tick;
    logic       start_btn;
    logic [1:0] game_state;
    logic [7:0] score;
    logic       hit;
    logic       freeze;

    int checks;
    int failures;

    bird_collision dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .game_state (game_state),
        .score      (score),
        .hit        (hit),
        .freeze     (freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One evaluated frame with the given geometry; returns 1 ns after the edge.
    task automatic frame(input int by, input int px, input int gy);
        @(negedge clk);
        bird_y     = 10'(by);
        pipe_x     = 10'(px);
        gap_y      = 10'(gy);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    // Press then release start_btn; state change is visible after the press edge.
    task automatic press();
        @(negedge clk);
        start_btn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start_btn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        start_btn  = 1'b0;
        frame_tick = 1'b0;
        bird_y     = 10'd200;
        pipe_x     = 10'd600;
        gap_y      = 10'd180;
        #12;
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // frame_tick in IDLE with a passing pipe must not score
        frame(200, 48, 180);
        check("idle_tick_score", 32'(score), 32'd0);
        check("idle_tick_state", 32'(game_state), 32'd0);

        press();
        check("start_state", 32'(game_state), 32'd1);
        check("start_freeze", 32'(freeze), 32'd0);
        check("start_score", 32'(score), 32'd0);

        frame(200, 120, 180);
        check("in_gap_state", 32'(game_state), 32'd1);
        check("in_gap_hit", 32'(hit), 32'd0);

        press();
        check("play_press_ign", 32'(game_state), 32'd1);

        // Exact gap edges, strict horizontal edge, one pixel above ground
        frame(180, 120, 180);
        check("gap_top_edge", 32'(game_state), 32'd1);
        frame(268, 120, 180);
        check("gap_bot_edge", 32'(game_state), 32'd1);
        frame(100, 132, 180);
        check("pipe_right_of", 32'(game_state), 32'd1);
        frame(447, 600, 180);
        check("above_ground", 32'(game_state), 32'd1);

        // Scoring sequence
        frame(200, 50, 180);
        check("score_px50", 32'(score), 32'd0);
        frame(200, 48, 180);
        check("score_px48", 32'(score), 32'd1);
        frame(200, 40, 180);
        check("score_px40", 32'(score), 32'd1);
        frame(200, 600, 180);
        check("score_px600", 32'(score), 32'd1);
        frame(200, 48, 180);
        check("score_2nd_pass", 32'(score), 32'd2);

        // One pixel past the gap bottom with the pipe overlapping -> crash
        frame(269, 120, 180);
        check("crash_state", 32'(game_state), 32'd2);
        check("crash_hit", 32'(hit), 32'd1);
        check("crash_freeze", 32'(freeze), 32'd1);
        check("crash_score", 32'(score), 32'd2);
        @(posedge clk);
        #1;
        check("hit_one_cycle", 32'(hit), 32'd0);

        frame(100, 120, 180);
        check("dead_tick_hit", 32'(hit), 32'd0);
        check("dead_tick_state", 32'(game_state), 32'd2);

        press();
        check("dead_to_idle", 32'(game_state), 32'd0);
        check("idle_score_hold", 32'(score), 32'd2);
        press();
        check("round2_state", 32'(game_state), 32'd1);
        check("round2_score", 32'(score), 32'd0);

        // Bird above gap but pipe trailing edge exactly at BIRD_X: no overlap, a pass
        frame(100, 600, 180);
        frame(100, 48, 180);
        check("trail_edge_state", 32'(game_state), 32'd1);
        check("trail_edge_score", 32'(score), 32'd1);

        // Ground crash and pass on the same frame: crash wins
        frame(200, 600, 180);
        frame(448, 48, 180);
        check("ground_state", 32'(game_state), 32'd2);
        check("ground_hit", 32'(hit), 32'd1);
        check("ground_no_score", 32'(score), 32'd1);

        // Saturation
        press();
        press();
        check("round3_state", 32'(game_state), 32'd1);
        for (int i = 0; i < 254; i++) begin
            frame(200, 600, 180);
            frame(200, 48, 180);
        end
        check("score_254", 32'(score), 32'd254);
        frame(200, 600, 180);
        frame(200, 48, 180);
        check("score_255", 32'(score), 32'd255);
        frame(200, 600, 180);
        frame(200, 48, 180);
        check("score_sat", 32'(score), 32'd255);

        // Round with score 5, then asynchronous reset mid-round
        frame(448, 600, 180);
        press();
        press();
        for (int i = 0; i < 5; i++) begin
            frame(200, 600, 180);
            frame(200, 48, 180);
        end
        check("score_5", 32'(score), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(game_state), 32'd0);
        check("arst_score", 32'(score), 32'd0);
        check("arst_hit", 32'(hit), 32'd0);
        check("arst_freeze", 32'(freeze), 32'd1);

        // Button held across reset release must not start a round
        start_btn = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("held_btn_idle", 32'(game_state), 32'd0);
        @(negedge clk);
        start_btn = 1'b0;
        @(posedge clk);
        #1;
        check("release_idle", 32'(game_state), 32'd0);
        press();
        check("repress_play", 32'(game_state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
